// File: rtl/key_conditioner.sv
// Per-key conditioning for active-low push-buttons: 2-flop synchroniser, counter debounce,
// one-cycle press/release/long-press pulses and a press-toggled level.
module key_conditioner #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int CNT_W           = 27
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_toggle
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] sync2_q;
   logic [NUM_KEYS-1:0] sample;

   // Synchronisers reset to "released" so a key held through reset is seen as a fresh press.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= KEY;
         sync2_q <= sync1_q;
      end
   end

   assign sample = ~sync2_q;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_state_e       state_q, state_d;
      logic [CNT_W-1:0] deb_q, deb_d;
      logic [CNT_W-1:0] hold_q, hold_d;
      logic             long_done_q, long_done_d;
      logic             level_q, level_d;
      logic             toggle_q, toggle_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             long_q, long_d;

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
         if (!RESET_N) begin
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            toggle_q    <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
         end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            toggle_q    <= toggle_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
         end
      end

      // NOTE: every variable gets a default before the case so no latch is inferred.
      always_comb begin
         state_d     = state_q;
         deb_d       = deb_q;
         hold_d      = hold_q;
         long_done_d = long_done_q;
         case (state_q)
            IDLE: begin
               if (sample[k]) begin
                  state_d = PRESS_WAIT;
                  deb_d   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sample[k]) begin
                  state_d = IDLE;
               end else if (deb_q == DEB_LAST) begin
                  state_d     = HELD;
                  hold_d      = '0;
                  long_done_d = 1'b0;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end
            HELD: begin
               if (!sample[k]) begin
                  state_d = RELEASE_WAIT;
                  deb_d   = '0;
               end else if (hold_q == LONG_LAST) begin
                  long_done_d = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               // A bounce back to pressed keeps the hold count and long-press arming.
               if (sample[k]) begin
                  state_d = HELD;
               end else if (deb_q == DEB_LAST) begin
                  state_d = IDLE;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         level_d   = level_q;
         toggle_d  = toggle_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;
         case (state_q)
            PRESS_WAIT: begin
               if (sample[k] && deb_q == DEB_LAST) begin
                  level_d  = 1'b1;
                  press_d  = 1'b1;
                  toggle_d = ~toggle_q;
               end
            end
            HELD: begin
               if (sample[k] && hold_q == LONG_LAST && !long_done_q) begin
                  long_d = 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (!sample[k] && deb_q == DEB_LAST) begin
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      assign key_level[k]   = level_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = release_q;
      assign key_long[k]    = long_q;
      assign key_toggle[k]  = toggle_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected pulses are queued at stimulus time and
// compared every cycle against the outputs, with level/toggle tracked from those pulses.
module tb_key_conditioner;

   localparam int NK   = 4;
   localparam int DEB  = 4;
   localparam int LONG = 16;
   localparam int CW   = 8;
   localparam int LAT  = 3 + DEB;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key   = '1;
   logic [NK-1:0] key_level, key_press, key_release, key_long, key_toggle;

   key_conditioner #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONG),
      .CNT_W          (CW)
   ) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .KEY        (key),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long),
      .key_toggle (key_toggle)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic [NK-1:0] lng;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Sorted insert so the monitor can pop in cycle order.
   task automatic push_exp(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r,
                           input logic [NK-1:0] l);
      exp_t e;
      int   idx;
      e.at    = at;
      e.press = p;
      e.rel   = r;
      e.lng   = l;
      idx     = 0;
      for (int i = 0; i < sb.size(); i++) if (sb[i].at <= at) idx = i + 1;
      sb.insert(idx, e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [NK-1:0] m_level  = '0;
   logic [NK-1:0] m_toggle = '0;
   logic [NK-1:0] ep, er, el;
   exp_t          pe;

   always @(negedge clk) begin
      ep = '0;
      er = '0;
      el = '0;
      if (!rst_n) begin
         m_level  = '0;
         m_toggle = '0;
      end else begin
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            pe = sb.pop_front();
            check("sb_cycle", pe.at, cyc);
            ep |= pe.press;
            er |= pe.rel;
            el |= pe.lng;
         end
         m_level  = (m_level | ep) & ~er;
         m_toggle = m_toggle ^ ep;
      end
      check("mon_press",   key_press,   ep);
      check("mon_release", key_release, er);
      check("mon_long",    key_long,    el);
      check("mon_level",   key_level,   m_level);
      check("mon_toggle",  key_toggle,  m_toggle);
   end

   int t;

   initial begin
      rst_n = 1'b0;
      key   = '1;
      step(3);
      check("rst_level",  key_level,  0);
      check("rst_toggle", key_toggle, 0);
      rst_n = 1'b1;
      step(2);

      // Clean press on key 0.
      t      = cyc;
      key[0] = 1'b0;
      push_exp(t + LAT, 4'b0001, 4'b0000, 4'b0000);
      step(LAT);
      check("s1_press",  key_press,  4'b0001);
      check("s1_level",  key_level,  4'b0001);
      check("s1_toggle", key_toggle, 4'b0001);
      step(1);
      check("s1_press_end", key_press, 4'b0000);

      // Release with one bounce on key 0.
      step(2);
      key[0] = 1'b1;
      step(2);
      key[0] = 1'b0;
      step(1);
      key[0] = 1'b1;
      t      = cyc;
      push_exp(t + LAT, 4'b0000, 4'b0001, 4'b0000);
      for (int i = 1; i < LAT; i++) begin
         step(1);
         check("s3_level_hold", key_level[0], 1'b1);
      end
      step(1);
      check("s3_release", key_release, 4'b0001);
      check("s3_level",   key_level,   4'b0000);
      step(4);

      // Bounce rejection on key 1.
      key[1] = 1'b0;
      step(3);
      key[1] = 1'b1;
      step(5);
      key[1] = 1'b0;
      step(2);
      key[1] = 1'b1;
      step(12);
      check("s2_level", key_level[1], 1'b0);

      // Long press on key 2.
      t      = cyc;
      key[2] = 1'b0;
      push_exp(t + LAT, 4'b0100, 4'b0000, 4'b0000);
      push_exp(t + LAT + LONG, 4'b0000, 4'b0000, 4'b0100);
      step(LAT + LONG);
      check("s4_long", key_long, 4'b0100);
      step(40 - LAT - LONG);
      key[2] = 1'b1;
      t      = cyc;
      push_exp(t + LAT, 4'b0000, 4'b0100, 4'b0000);
      step(LAT);
      check("s4_release", key_release, 4'b0100);
      step(3);

      // Reset while key 1 is held, then key 1 still low through reset release.
      t      = cyc;
      key[1] = 1'b0;
      push_exp(t + LAT, 4'b0010, 4'b0000, 4'b0000);
      step(10);
      check("s6_held", key_level, 4'b0010);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("s6_rst_level",   key_level,   0);
      check("s6_rst_toggle",  key_toggle,  0);
      check("s6_rst_press",   key_press,   0);
      check("s6_rst_release", key_release, 0);
      check("s6_rst_long",    key_long,    0);
      step(3);
      rst_n = 1'b1;
      t     = cyc;
      push_exp(t + LAT, 4'b0010, 4'b0000, 4'b0000);
      step(LAT);
      check("s6_press", key_press, 4'b0010);
      step(3);
      key[1] = 1'b1;
      t      = cyc;
      push_exp(t + LAT, 4'b0000, 4'b0010, 4'b0000);
      step(LAT + 3);

      // Simultaneous presses on keys 0 and 3.
      for (int i = 0; i < 3; i++) begin
         t      = cyc;
         key[0] = 1'b0;
         key[3] = 1'b0;
         push_exp(t + LAT, 4'b1001, 4'b0000, 4'b0000);
         step(LAT);
         check("s5_press", key_press, 4'b1001);
         step(3);
         key[0] = 1'b1;
         key[3] = 1'b1;
         t      = cyc;
         push_exp(t + LAT, 4'b0000, 4'b1001, 4'b0000);
         step(LAT);
         check("s5_release", key_release, 4'b1001);
         step(5);
      end
      check("s5_toggle", {key_toggle[3], key_toggle[0]}, 2'b11);
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
